muldiv_sequencer: RTL
=====================

# muldiv_sequencer

Multi-cycle RV32M multiply/divide unit for the RISC-V core's execute stage. It accepts one operation at a time from the decode/execute boundary through a valid/ready handshake. It iterates a shift-add multiplier or restoring divider over 32 cycles and returns a 32-bit result through a second valid/ready handshake. The pipeline holds execute while `Busy` is high, and uses `Kill` to drop an in-flight operation on branch mispredict or flush.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `Clock` in 1: the single clock; all state changes on its rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `InValid` in 1: an operation is presented on `Funct3`, `A`, `B`.
- `InReady` out 1: the unit can accept an operation. High only in IDLE.
- `Funct3` in 3: RV32M funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- `A`, `B` in 32: rs1 and rs2 operands.
- `Kill` in 1: abort the current operation; no result is produced.
- `OutValid` out 1: `Result` is valid.
- `OutReady` in 1: the consumer takes `Result`.
- `Result` out 32: the operation result.
- `Busy` out 1: the FSM is not in IDLE. Drives the execute-stage stall.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- **IDLE:** the unit accepts when `InValid` is high and `Kill` is low. On accept it latches `Funct3`, `A`, `B` and goes to PREP.
- **PREP:** forms the operand magnitudes and records the result sign per `Funct3`.
  - MULHSU treats `A` as signed and `B` as unsigned.
  - If a special case applies, PREP loads the final result and goes straight to DONE. Otherwise it clears the 6-bit counter and goes to ITER.
- **ITER:** performs one step per cycle for 32 cycles, then goes to FIX.
  - Multiply: shift-add into a 64-bit product.
  - Divide: restoring step using a 33-bit subtract. The quotient shifts in, and the partial remainder is kept.
- **FIX:** conditionally negates (two's complement) the result.
  - For MUL, the low 32 bits are selected; for MULH*, the high 32 bits.
  - Quotient sign is sign(A) XOR sign(B); remainder sign is sign(A).
  - Goes to DONE.
- **DONE:** `OutValid` is high and `Result` is held stable until `OutValid && OutReady`, then the FSM returns to IDLE.
- Special cases, all resolved in PREP:
  - DIV/DIVU by zero gives 0xFFFFFFFF.
  - REM/REMU by zero gives `A`.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF gives 0.
- **Kill:** in any state, the next state is IDLE. `OutValid` drops in the next cycle and `Result` is not updated. If `Kill` is high in IDLE while `InValid` is high, the operation is not accepted.
- All arithmetic is modulo 2^32 on output. There are no exceptions or flags.

## Timing
- Reset values:
  - state = IDLE
  - `InReady` = 1
  - `OutValid` = 0
  - `Busy` = 0
  - `Result` = 0
  - counter = 0
  - all operand registers = 0
- `Reset_n` asserted mid-operation forces IDLE asynchronously and loses the operation.
- Latency, with the accept edge as cycle 0:
  - PREP is cycle 1.
  - ITER is cycles 2–33.
  - FIX is cycle 34.
  - `OutValid` is first high in cycle 35.
  - Special cases: `OutValid` is high in cycle 2.
- Back-pressure: DONE persists for any number of cycles with `OutReady` low. Throughput is one operation per 36 cycles when there is no back-pressure.
- `InReady` is combinational from state. `OutValid`, `Result`, and `Busy` are registered (state-decoded). No output depends combinationally on `OutReady`.
- Counter wrap: ITER exits when counter == 31 at that step. The counter never runs past 31.

## Structure
- New shared header `MulDiv.vh`, included alongside `Opcode.vh`:
  - the `FNC_MUL` … `FNC_REMU` funct3 defines;
  - the state encoding;
  - `MD_ITERS` = 32.
- One sub-module, `muldiv_iter`, holds:
  - the 64-bit product/remainder-quotient shift register;
  - the 33-bit add/subtract;
  - one step per enable.
- The top level holds the FSM, counter, sign/special-case logic and handshake.

## Test plan
- MUL A=7, B=0xFFFFFFFD → `Result` 0xFFFFFFEB, `OutValid` first high exactly 35 cycles after accept.
- MULH A=B=0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases with `OutValid` at cycle 2:
  - DIVU 5/0 → 0xFFFFFFFF;
  - REMU 5/0 → 5;
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
- `Kill` pulsed at cycle 10 of a DIV → `OutValid` never rises, `InReady` = 1 in cycle 11, and a following MUL 3×4 returns 12. `Reset_n` low mid-ITER → all outputs at reset values immediately.
- `OutReady` held low 5 cycles in DONE → `Result` and `OutValid` stable. `InValid` held high during that time is not accepted until the cycle after the handshake.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer:
// funct3 codes, FSM state encoding and the iteration count.
package muldiv_sequencer_pkg;

    localparam logic [2:0] FNC_MUL    = 3'd0;
    localparam logic [2:0] FNC_MULH   = 3'd1;
    localparam logic [2:0] FNC_MULHSU = 3'd2;
    localparam logic [2:0] FNC_MULHU  = 3'd3;
    localparam logic [2:0] FNC_DIV    = 3'd4;
    localparam logic [2:0] FNC_DIVU   = 3'd5;
    localparam logic [2:0] FNC_REM    = 3'd6;
    localparam logic [2:0] FNC_REMU   = 3'd7;

    localparam int MD_ITERS = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_e;

endpackage

// File: rtl/muldiv_sequencer_iter.sv
// Iteration datapath: one shift-add multiply step or one restoring divide
// step per enable, sharing a single XLEN+1 bit adder/subtractor.
// Multiply: r_acc = {product_hi, multiplier shifting out}.
// Divide:   r_acc = {partial remainder, dividend/quotient shifting}.
module muldiv_sequencer_iter #(
    parameter int XLEN = 32
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_is_div,
    input  logic [XLEN-1:0]   i_a_mag,
    input  logic [XLEN-1:0]   i_b_mag,
    output logic [2*XLEN-1:0] o_acc
);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opb;

    logic [XLEN:0]     w_op_a;
    logic [XLEN:0]     w_op_b;
    logic [XLEN:0]     w_cin;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_next_acc;

    // One shared add (multiply) / subtract (divide) and the next shift-register value
    always_comb begin
        w_op_a     = '0;
        w_op_b     = '0;
        w_cin      = '0;
        w_next_acc = r_acc;
        if (i_is_div) begin
            // Shifted partial remainder minus divisor; a clear top bit means it fits.
            w_op_a = r_acc[2*XLEN-1:XLEN-1];
            w_op_b = ~{1'b0, r_opb};
            w_cin  = {{XLEN{1'b0}}, 1'b1};
        end else begin
            w_op_a = {1'b0, r_acc[2*XLEN-1:XLEN]};
            w_op_b = r_acc[0] ? {1'b0, r_opb} : '0;
        end
        w_sum = w_op_a + w_op_b + w_cin;
        if (i_is_div) begin
            if (!w_sum[XLEN]) begin
                w_next_acc = {w_sum[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            end else begin
                w_next_acc = {w_op_a[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
            end
        end else begin
            w_next_acc = {w_sum, r_acc[XLEN-1:1]};
        end
    end

    // Load magnitudes at the start of an operation, then step once per enable
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_acc <= '0;
            r_opb <= '0;
        end else if (i_load) begin
            r_acc <= {{XLEN{1'b0}}, i_a_mag};
            r_opb <= i_b_mag;
        end else if (i_step) begin
            r_acc <= w_next_acc;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: accepts one operation, resolves signs and
// special cases, iterates 32 steps in muldiv_sequencer_iter, fixes the sign
// and holds the result until the consumer takes it.
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Input side additionally requires Kill low; output Result is stable while
// OutValid is high and OutReady is low.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic            InValid,
    output logic            InReady,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            Kill,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [XLEN-1:0] Result,
    output logic            Busy,
    output md_state_e       o_dbg_state
);

    localparam logic [5:0] CNT_LAST = 6'(MD_ITERS - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         r_state;
    md_state_e         w_next_state;
    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic              r_neg;
    logic [5:0]        r_cnt;
    logic [XLEN-1:0]   r_result;
    logic              r_out_valid;
    logic              r_busy;

    logic              w_accept;
    logic              w_iter_load;
    logic              w_iter_step;
    logic              w_load_special;
    logic              w_load_fix;
    logic [2*XLEN-1:0] w_acc;

    // Operand classification for the latched operation
    logic              w_is_div;
    logic              w_is_rem;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_neg_res;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;

    assign w_is_div   = r_funct3[2];
    assign w_is_rem   = r_funct3[2] & r_funct3[1];
    assign w_a_signed = (r_funct3 == FNC_MULH) || (r_funct3 == FNC_MULHSU) ||
                        (r_funct3 == FNC_DIV)  || (r_funct3 == FNC_REM);
    assign w_b_signed = (r_funct3 == FNC_MULH) || (r_funct3 == FNC_DIV) ||
                        (r_funct3 == FNC_REM);
    assign w_a_neg    = w_a_signed & r_a[XLEN-1];
    assign w_b_neg    = w_b_signed & r_b[XLEN-1];
    assign w_a_mag    = w_a_neg ? -r_a : r_a;
    assign w_b_mag    = w_b_neg ? -r_b : r_b;
    // Remainder takes the dividend's sign; products and quotients the XOR.
    assign w_neg_res  = w_is_rem ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_div_zero = w_is_div && (r_b == '0);
    assign w_div_ovf  = w_is_div && !r_funct3[0] && (r_a == INT_MIN) && (r_b == '1);
    assign w_special  = w_div_zero || w_div_ovf;

    // Final value for divide-by-zero and signed overflow, bypassing iteration
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = w_is_rem ? r_a : '1;
        end else if (w_div_ovf) begin
            w_special_res = w_is_rem ? '0 : INT_MIN;
        end
    end

    logic [2*XLEN-1:0] w_prod_fixed;
    logic [XLEN-1:0]   w_div_part;
    logic [XLEN-1:0]   w_fix_res;

    // Sign fix-up and half/part selection of the iteration result
    always_comb begin
        w_prod_fixed = r_neg ? -w_acc : w_acc;
        w_div_part   = w_is_rem ? w_acc[2*XLEN-1:XLEN] : w_acc[XLEN-1:0];
        w_fix_res    = '0;
        if (w_is_div) begin
            w_fix_res = r_neg ? -w_div_part : w_div_part;
        end else if (r_funct3 == FNC_MUL) begin
            w_fix_res = w_prod_fixed[XLEN-1:0];
        end else begin
            w_fix_res = w_prod_fixed[2*XLEN-1:XLEN];
        end
    end

    // State register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; Kill overrides everything
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (InValid) w_next_state = ST_PREP;
            ST_PREP: w_next_state = w_special ? ST_DONE : ST_ITER;
            ST_ITER: if (r_cnt == CNT_LAST) w_next_state = ST_FIX;
            ST_FIX:  w_next_state = ST_DONE;
            ST_DONE: if (OutReady) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
        if (Kill) w_next_state = ST_IDLE;
    end

    // State-decoded controls and the combinational input ready
    always_comb begin
        InReady        = (r_state == ST_IDLE);
        w_accept       = (r_state == ST_IDLE) && InValid && !Kill;
        w_iter_load    = (r_state == ST_PREP) && !w_special && !Kill;
        w_iter_step    = (r_state == ST_ITER) && !Kill;
        w_load_special = (r_state == ST_PREP) && w_special && !Kill;
        w_load_fix     = (r_state == ST_FIX) && !Kill;
    end

    // Operand capture on accept and sign capture in PREP
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_funct3 <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_neg    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_funct3 <= Funct3;
                r_a      <= A;
                r_b      <= B;
            end
            if (r_state == ST_PREP) begin
                r_neg <= w_neg_res;
            end
        end
    end

    // Step counter: cleared in PREP, saturates at the last step
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt <= '0;
        end else if (r_state == ST_PREP) begin
            r_cnt <= '0;
        end else if (w_iter_step && (r_cnt != CNT_LAST)) begin
            r_cnt <= r_cnt + 6'd1;
        end
    end

    // Result register, only written when a finished value enters DONE
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_result <= '0;
        end else if (w_load_special) begin
            r_result <= w_special_res;
        end else if (w_load_fix) begin
            r_result <= w_fix_res;
        end
    end

    // Registered, state-decoded status outputs
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_out_valid <= (w_next_state == ST_DONE);
            r_busy      <= (w_next_state != ST_IDLE);
        end
    end

    muldiv_sequencer_iter #(.XLEN(XLEN)) u_iter (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .i_load   (w_iter_load),
        .i_step   (w_iter_step),
        .i_is_div (w_is_div),
        .i_a_mag  (w_a_mag),
        .i_b_mag  (w_b_mag),
        .o_acc    (w_acc)
    );

    assign OutValid    = r_out_valid;
    assign Result      = r_result;
    assign Busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule
